// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; the first bit is resolved on the accept edge.
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic [1:0]      div_signed,
    input  logic            div_quotient,
    input  logic            inst_32,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int H  = XLEN / 2;
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_dvsr;
    logic            r_q_neg;
    logic            r_r_neg;
    logic            r_sel_q;
    logic            r_w;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;

    function automatic logic [XLEN-1:0] f_fmt(input logic w, input logic [XLEN-1:0] v);
        return w ? {{H{v[H-1]}}, v[H-1:0]} : v;
    endfunction

    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_a_align;
    logic [XLEN-1:0] w_min;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_sp_res;

    assign w_a = inst_32 ? {{H{div_signed[1] & dividend[H-1]}}, dividend[H-1:0]} : dividend;
    assign w_b = inst_32 ? {{H{div_signed[0] & divisor[H-1]}}, divisor[H-1:0]} : divisor;
    assign w_a_neg = div_signed[1] & w_a[XLEN-1];
    assign w_b_neg = div_signed[0] & w_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -w_a : w_a;
    assign w_b_mag = w_b_neg ? -w_b : w_b;
    // Word magnitudes sit in the top half so the shift-out sees them first.
    assign w_a_align = inst_32 ? {w_a_mag[H-1:0], {H{1'b0}}} : w_a_mag;
    assign w_min = inst_32 ? {{(H+1){1'b1}}, {(H-1){1'b0}}}
                           : {1'b1, {(XLEN-1){1'b0}}};
    assign w_b_zero  = (w_b == '0);
    assign w_ovf     = div_signed[1] & div_signed[0] & (w_a == w_min) & (&w_b);
    assign w_special = w_b_zero | w_ovf;
    assign w_sp_res  = f_fmt(inst_32, div_quotient
                           ? (w_b_zero ? {XLEN{1'b1}} : w_a)
                           : (w_b_zero ? w_a : {XLEN{1'b0}}));

    logic [XLEN-1:0] w_s_rem;
    logic [XLEN-1:0] w_s_quot;
    logic [XLEN-1:0] w_s_dvsr;
    logic [XLEN:0]   w_sh;
    logic [XLEN:0]   w_sub;
    logic            w_ge;
    logic [XLEN-1:0] w_n_rem;
    logic [XLEN-1:0] w_n_quot;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_res;

    // The step datapath is shared between the accept edge and CALC.
    assign w_s_rem  = (r_state == IDLE) ? '0        : r_rem;
    assign w_s_quot = (r_state == IDLE) ? w_a_align : r_quot;
    assign w_s_dvsr = (r_state == IDLE) ? w_b_mag   : r_dvsr;
    assign w_sh     = {w_s_rem, w_s_quot[XLEN-1]};
    assign w_sub    = w_sh - {1'b0, w_s_dvsr};
    assign w_ge     = ~w_sub[XLEN];
    assign w_n_rem  = w_ge ? w_sub[XLEN-1:0] : w_sh[XLEN-1:0];
    assign w_n_quot = {w_s_quot[XLEN-2:0], w_ge};
    assign w_q_fix  = r_q_neg ? -w_n_quot : w_n_quot;
    assign w_r_fix  = r_r_neg ? -w_n_rem : w_n_rem;
    assign w_res    = f_fmt(r_w, r_sel_q ? w_q_fix : w_r_fix);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_dvsr      <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_sel_q     <= 1'b0;
            r_w         <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (div_valid) begin
                        r_sel_q <= div_quotient;
                        r_w     <= inst_32;
                        if (w_special) begin
                            r_result    <= w_sp_res;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_rem   <= w_n_rem;
                            r_quot  <= w_n_quot;
                            r_dvsr  <= w_b_mag;
                            r_q_neg <= w_a_neg ^ w_b_neg;
                            r_r_neg <= w_a_neg;
                            r_cnt   <= inst_32 ? CW'(H - 1) : CW'(XLEN - 1);
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem  <= w_n_rem;
                    r_quot <= w_n_quot;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_result    <= w_res;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign div_ready = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
